// File: rtl/vec_stream_checker.sv
// Streaming checker: compares N valid/ready beats against a packed
// vector literal and reports done/pass for the end-of-test stop stage.
//
// Ports:
//   clock, reset (async, active-low)
//   start      arm the check (IDLE only)
//   clear      back to IDLE from any state, results zeroed
//   in_valid / in_ready / in_bits   element stream (in_ready only in RUN)
//   done       result available (PASS, FAIL or TMO)
//   pass       all N elements matched
//   first_bad  index of the first mismatching element
//   err_count  number of mismatching elements
//   timed_out  RUN stalled for TIMEOUT cycles
//
// Optional feature: define VEC_CHECK_TIMEOUT_EN to enable the RUN stall
// timeout (TMO state). Without it RUN waits forever and timed_out is 0.

module vec_stream_checker #(
   parameter int unsigned        W        = 8,
   parameter int unsigned        N        = 4,
   parameter logic [N*W-1:0]     EXPECTED = '0,
   parameter int unsigned        TIMEOUT  = 1024,
   localparam int unsigned       IW       = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned       CW       = $clog2(N + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_bits,
   output logic          done,
   output logic          pass,
   output logic [IW-1:0] first_bad,
   output logic [CW-1:0] err_count,
   output logic          timed_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TMO
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] fb_q, fb_d;
   logic [CW-1:0] ec_q, ec_d;
   logic          err_q, err_d;

   logic          beat;
   logic          mism;
   logic          last;

   logic [W-1:0]  exp_a [N];

   for (genvar i = 0; i < N; i++) begin : g_exp
      assign exp_a[i] = EXPECTED[i*W +: W];
   end

`ifdef VEC_CHECK_TIMEOUT_EN
   localparam int unsigned SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall_q, stall_d;
`endif

   // Handshake depends on state only, never on in_valid.
   assign in_ready = (state_q == S_RUN);
   assign beat     = in_valid & in_ready;
   assign mism     = (in_bits != exp_a[idx_q]);
   assign last     = (idx_q == IW'(N - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      fb_d    = fb_q;
      ec_d    = ec_q;
      err_d   = err_q;
`ifdef VEC_CHECK_TIMEOUT_EN
      stall_d = stall_q;
`endif
      if (clear) begin
         // Clear wins over start and over a beat in the same cycle.
         state_d = S_IDLE;
         idx_d   = '0;
         fb_d    = '0;
         ec_d    = '0;
         err_d   = 1'b0;
`ifdef VEC_CHECK_TIMEOUT_EN
         stall_d = '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_RUN;
                  idx_d   = '0;
                  fb_d    = '0;
                  ec_d    = '0;
                  err_d   = 1'b0;
`ifdef VEC_CHECK_TIMEOUT_EN
                  stall_d = '0;
`endif
               end
            end
            S_RUN: begin
               if (beat) begin
`ifdef VEC_CHECK_TIMEOUT_EN
                  stall_d = '0;
`endif
                  if (mism) begin
                     if (ec_q != CW'(N)) begin
                        ec_d = ec_q + CW'(1);
                     end
                     // Only the first mismatch records its index.
                     if (!err_q) begin
                        fb_d  = idx_q;
                        err_d = 1'b1;
                     end
                  end
                  if (last) begin
                     idx_d   = '0;
                     state_d = (err_q | mism) ? S_FAIL : S_PASS;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
`ifdef VEC_CHECK_TIMEOUT_EN
                  stall_d = stall_q + SW'(1);
                  if (stall_d == SW'(TIMEOUT)) begin
                     state_d = S_TMO;
                  end
`endif
               end
            end
            default: begin
               // PASS / FAIL / TMO hold until clear or reset.
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         fb_q    <= '0;
         ec_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fb_q    <= fb_d;
         ec_q    <= ec_d;
         err_q   <= err_d;
      end
   end

`ifdef VEC_CHECK_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign timed_out = (state_q == S_TMO);
`else
   // TIMEOUT has no effect without the stall counter.
   assign timed_out = 1'b0 & (TIMEOUT == 0);
`endif

   assign done      = (state_q == S_PASS) |
                      (state_q == S_FAIL) |
                      (state_q == S_TMO);
   assign pass      = (state_q == S_PASS);
   assign first_bad = fb_q;
   assign err_count = ec_q;

endmodule

// File: tb/tb_vec_stream_checker.sv
// Bench for vec_stream_checker: table of whole transactions with a
// result scoreboard, plus hand-written multi-cycle corner sequences.

module tb_vec_stream_checker;

   localparam int W = 8;
   localparam int N = 4;
   localparam logic [31:0] EXP = 32'h04030201;

   logic       clock = 1'b0;
   logic       reset;
   logic       start, clear, in_valid;
   logic       in_ready;
   logic [7:0] in_bits;
   logic       done, pass;
   logic [1:0] first_bad;
   logic [2:0] err_count;
   logic       timed_out;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] data;
      bit          gap;
      bit          pass;
      logic [1:0]  fb;
      logic [2:0]  ec;
   } vec_t;

   typedef struct {
      bit         pass;
      logic [1:0] fb;
      logic [2:0] ec;
   } res_t;

   vec_t tbl[7];
   res_t sb[$];

   vec_stream_checker #(
      .W(W), .N(N), .EXPECTED(EXP), .TIMEOUT(8)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
      .done(done), .pass(pass), .first_bad(first_bad),
      .err_count(err_count), .timed_out(timed_out)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_pass"}, 32'(pass), 0);
      chk({nm, "_rdy"},  32'(in_ready), 0);
      chk({nm, "_ec"},   32'(err_count), 0);
      chk({nm, "_fb"},   32'(first_bad), 0);
      chk({nm, "_tmo"},  32'(timed_out), 0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic do_start(input string nm);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, "_rdy_run"}, 32'(in_ready), 1);
   endtask

   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_bits  = d;
      tick();
      in_valid = 1'b0;
      in_bits  = 8'h5A;
   endtask

   task automatic beats(input logic [31:0] d, input bit gap,
                        input string nm);
      logic [31:0] dd;
      dd = d;
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) chk({nm, "_early_done"}, 32'(done), 0);
         send(dd[i*8 +: 8]);
         if (gap && i != N - 1) tick();
      end
   endtask

   task automatic collect(input string nm);
      int   k;
      res_t r;
      k = 0;
      while (!done && k < 4) begin
         tick();
         k++;
      end
      chk({nm, "_latency"}, 32'(k), 0);
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 1, 0);
      end else begin
         r = sb.pop_front();
         chk({nm, "_done"}, 32'(done), 1);
         chk({nm, "_pass"}, 32'(pass), 32'(r.pass));
         chk({nm, "_ec"},   32'(err_count), 32'(r.ec));
         chk({nm, "_fb"},   32'(first_bad), 32'(r.fb));
         chk({nm, "_rdy"},  32'(in_ready), 0);
      end
   endtask

   initial begin
      tbl[0] = '{32'h04030201, 1'b0, 1'b1, 2'd0, 3'd0};
      tbl[1] = '{32'hEE03FF01, 1'b0, 1'b0, 2'd1, 3'd2};
      tbl[2] = '{32'h04030201, 1'b1, 1'b1, 2'd0, 3'd0};
      tbl[3] = '{32'h00000000, 1'b0, 1'b0, 2'd0, 3'd4};
      tbl[4] = '{32'h05030201, 1'b0, 1'b0, 2'd3, 3'd1};
      tbl[5] = '{32'h04030202, 1'b1, 1'b0, 2'd0, 3'd1};
      tbl[6] = '{32'h04FF02FF, 1'b1, 1'b0, 2'd0, 3'd2};

      reset    = 1'b0;
      start    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_bits  = 8'h00;
      tick();
      tick();
      chk_idle("reset");
      reset = 1'b1;
      tick();

      // Valid in IDLE is not accepted.
      in_valid = 1'b1;
      in_bits  = 8'h01;
      tick();
      chk("idle_rdy", 32'(in_ready), 0);
      in_valid = 1'b0;

      for (int v = 0; v < 7; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         do_clear();
         chk_idle({nm, "_clr"});
         do_start(nm);
         sb.push_back('{tbl[v].pass, tbl[v].fb, tbl[v].ec});
         beats(tbl[v].data, tbl[v].gap, nm);
         collect(nm);
      end

      // Results hold in FAIL: more beats and start are ignored.
      send(8'h04);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("hold_done", 32'(done), 1);
      chk("hold_ec", 32'(err_count), 2);
      chk("hold_pass", 32'(pass), 0);

      // Clear and start together: clear wins, stay in IDLE.
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      chk("clr_pri_rdy", 32'(in_ready), 0);
      chk("clr_pri_done", 32'(done), 0);

      // Clear on the 3rd valid beat, then a fresh full run.
      do_start("clrbeat");
      send(8'h01);
      send(8'hFF);
      chk("clrbeat_ec_mid", 32'(err_count), 1);
      in_valid = 1'b1;
      in_bits  = 8'hAA;
      clear    = 1'b1;
      tick();
      in_valid = 1'b0;
      clear    = 1'b0;
      chk_idle("clrbeat");
      do_start("clrbeat2");
      sb.push_back('{1'b1, 2'd0, 3'd0});
      beats(EXP, 1'b0, "clrbeat2");
      collect("clrbeat2");

      // Start inside RUN must not restart the element index.
      do_clear();
      do_start("runstart");
      send(8'h01);
      send(8'h02);
      start = 1'b1;
      tick();
      start = 1'b0;
      send(8'h03);
      send(8'h04);
      sb.push_back('{1'b1, 2'd0, 3'd0});
      collect("runstart");

      // Asynchronous reset mid-RUN.
      do_clear();
      do_start("arst");
      send(8'h01);
      send(8'h77);
      chk("arst_ec_pre", 32'(err_count), 1);
      chk("arst_fb_pre", 32'(first_bad), 1);
      #3 reset = 1'b0;
      #1;
      chk_idle("arst");
      tick();
      reset = 1'b1;
      tick();
      do_start("arst2");
      sb.push_back('{1'b1, 2'd0, 3'd0});
      beats(EXP, 1'b1, "arst2");
      collect("arst2");

      // Long stall in RUN.
      do_clear();
      do_start("stall");
`ifdef VEC_CHECK_TIMEOUT_EN
      for (int c = 0; c < 7; c++) tick();
      chk("tmo_early", 32'(done), 0);
      tick();
      chk("tmo_flag", 32'(timed_out), 1);
      chk("tmo_done", 32'(done), 1);
      chk("tmo_pass", 32'(pass), 0);
      chk("tmo_rdy", 32'(in_ready), 0);
      do_clear();
      chk_idle("tmo_clr");
`else
      for (int c = 0; c < 20; c++) tick();
      chk("stall_tmo", 32'(timed_out), 0);
      chk("stall_done", 32'(done), 0);
      chk("stall_rdy", 32'(in_ready), 1);
      send(8'h01);
      send(8'h02);
      send(8'h03);
      send(8'h04);
      sb.push_back('{1'b1, 2'd0, 3'd0});
      collect("stall");
`endif

      chk("sb_left", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
